// File: rtl/proc_trace_monitor.sv
// Trace monitor for the processor result buses: captures changed {ALU,MEM,RF}
// triples into a circular buffer, drained via pop/valid, and folds them into a MISR.
module proc_trace_monitor #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Clear,
  input  logic                     Capture_En,
  input  logic [WIDTH-1:0]         ALU_Out,
  input  logic [WIDTH-1:0]         MEM_Out,
  input  logic [WIDTH-1:0]         RFrd,
  input  logic                     Rd_Req,
  output logic                     Rd_Valid,
  output logic [WIDTH-1:0]         Rd_ALU,
  output logic [WIDTH-1:0]         Rd_MEM,
  output logic [WIDTH-1:0]         Rd_RF,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Overflow,
  output logic [31:0]              Signature
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   SIG_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]   POLY     = 32'h04C1_1DB7;

  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] mem;
    logic [WIDTH-1:0] rf;
  } trip_t;

  trip_t          r_mem [DEPTH];
  trip_t          r_last;
  trip_t          r_rd;
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_seen, r_ovf, r_rd_valid;
  logic [31:0]    r_sig;

  trip_t          w_trip;
  logic           w_full, w_empty, w_evt, w_pop, w_acc, w_drop;
  logic [31:0]    w_a32, w_m32, w_r32, w_mix, w_sig_next;

  assign w_trip  = '{alu: ALU_Out, mem: MEM_Out, rf: RFrd};
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Clear wins over any capture or pop presented in the same cycle.
  assign w_evt  = Capture_En & ~Clear & (~r_seen | (w_trip != r_last));
  assign w_pop  = Rd_Req & ~Clear & ~w_empty;
  assign w_acc  = w_evt & (~w_full | w_pop);
  assign w_drop = w_evt & w_full & ~w_pop;

  generate
    if (WIDTH >= 32) begin : g_trunc
      assign w_a32 = ALU_Out[31:0];
      assign w_m32 = MEM_Out[31:0];
      assign w_r32 = RFrd[31:0];
    end else begin : g_ext
      assign w_a32 = {{(32-WIDTH){1'b0}}, ALU_Out};
      assign w_m32 = {{(32-WIDTH){1'b0}}, MEM_Out};
      assign w_r32 = {{(32-WIDTH){1'b0}}, RFrd};
    end
  endgenerate

  // Rotations keep the three buses from cancelling when they carry equal values.
  assign w_mix      = w_a32 ^ {w_m32[15:0], w_m32[31:16]} ^ {w_r32[7:0], w_r32[31:8]};
  assign w_sig_next = ({r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0)) ^ w_mix;

  always_ff @(posedge Clk) begin
    if (w_acc) r_mem[r_wptr] <= w_trip;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_seen     <= 1'b0;
      r_ovf      <= 1'b0;
      r_sig      <= SIG_INIT;
      r_last     <= '0;
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
    end else if (Clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_seen     <= 1'b0;
      r_ovf      <= 1'b0;
      r_sig      <= SIG_INIT;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd   <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
      // Signature folds dropped events too, so it does not depend on DEPTH.
      if (w_evt) begin
        r_seen <= 1'b1;
        r_last <= w_trip;
        r_sig  <= w_sig_next;
      end
      if (w_acc)  r_wptr <= r_wptr + AW'(1);
      if (w_drop) r_ovf  <= 1'b1;
      if (w_acc && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_acc && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign Rd_Valid  = r_rd_valid;
  assign Rd_ALU    = r_rd.alu;
  assign Rd_MEM    = r_rd.mem;
  assign Rd_RF     = r_rd.rf;
  assign Count     = r_count;
  assign Full      = w_full;
  assign Empty     = w_empty;
  assign Overflow  = r_ovf;
  assign Signature = r_sig;
endmodule

// File: tb/tb_proc_trace_monitor.sv
// Bench for proc_trace_monitor: queue scoreboard plus a reference MISR, a vector
// table for change detection, and directed sequences for the multi-cycle corners.
module tb_proc_trace_monitor;
  localparam int DEPTH = 16;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  logic        Clk = 1'b0, Reset = 1'b0, Clear = 1'b0, Capture_En = 1'b0, Rd_Req = 1'b0;
  logic [31:0] ALU_Out = '0, MEM_Out = '0, RFrd = '0;
  logic        Rd_Valid, Full, Empty, Overflow;
  logic [31:0] Rd_ALU, Rd_MEM, Rd_RF, Signature;
  logic [4:0]  Count;

  proc_trace_monitor #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .Capture_En(Capture_En),
    .ALU_Out(ALU_Out), .MEM_Out(MEM_Out), .RFrd(RFrd), .Rd_Req(Rd_Req),
    .Rd_Valid(Rd_Valid), .Rd_ALU(Rd_ALU), .Rd_MEM(Rd_MEM), .Rd_RF(Rd_RF),
    .Count(Count), .Full(Full), .Empty(Empty), .Overflow(Overflow),
    .Signature(Signature));

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] a, m, r; } rec_t;
  typedef struct {
    bit cap; logic [31:0] alu; bit rd; bit clr;
    int cnt; bit rdv; logic [31:0] ralu; bit sigff;
  } vec_t;

  rec_t        q[$];
  rec_t        m_rd;
  logic [95:0] m_last;
  logic [31:0] m_sig;
  bit          m_seen, m_ovf, m_rdv;
  int          n_pass = 0, n_tot = 0;
  vec_t        tv[13];

  function automatic logic [31:0] misr(input logic [31:0] s, a, m, r);
    logic [31:0] x;
    x = a ^ {m[15:0], m[31:16]} ^ {r[7:0], r[31:8]};
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ x;
  endfunction

  function automatic vec_t mk(input bit cap, input logic [31:0] alu, input bit rd, clr,
                              input int cnt, input bit rdv, input logic [31:0] ralu,
                              input bit sigff);
    vec_t v;
    v.cap = cap; v.alu = alu; v.rd = rd; v.clr = clr;
    v.cnt = cnt; v.rdv = rdv; v.ralu = ralu; v.sigff = sigff;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_seen = 0; m_sig = FF; m_ovf = 0; m_rdv = 0; m_last = '0;
  endtask

  // One clock: drive, advance the model at the edge, compare just after it.
  task automatic cyc(input bit cap, input logic [31:0] a, m, r, input bit rd, clr);
    bit   evt, pop, full;
    rec_t t;
    Capture_En = cap; ALU_Out = a; MEM_Out = m; RFrd = r; Rd_Req = rd; Clear = clr;
    @(posedge Clk);
    evt  = cap && (!m_seen || {a, m, r} != m_last);
    pop  = rd && (q.size() != 0);
    full = (q.size() == DEPTH);
    if (clr) begin
      q.delete(); m_seen = 0; m_sig = FF; m_ovf = 0; m_rdv = 0;
    end else begin
      m_rdv = pop;
      if (pop) m_rd = q.pop_front();
      if (evt) begin
        m_seen = 1; m_last = {a, m, r}; m_sig = misr(m_sig, a, m, r);
        t.a = a; t.m = m; t.r = r;
        if (!full || pop) q.push_back(t);
        else m_ovf = 1;
      end
    end
    #1;
    chk("rd_valid", 32'(Rd_Valid), 32'(m_rdv));
    if (m_rdv) begin
      chk("rd_alu", Rd_ALU, m_rd.a);
      chk("rd_mem", Rd_MEM, m_rd.m);
      chk("rd_rf",  Rd_RF,  m_rd.r);
    end
    chk("count",     32'(Count),    32'(q.size()));
    chk("full",      32'(Full),     32'(q.size() == DEPTH));
    chk("empty",     32'(Empty),    32'(q.size() == 0));
    chk("overflow",  32'(Overflow), 32'(m_ovf));
    chk("signature", Signature,     m_sig);
  endtask

  initial begin
    model_reset();
    // Reset values, then release between edges.
    #22;
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_full",  32'(Full),  32'd0);
    chk("rst_ovf",   32'(Overflow), 32'd0);
    chk("rst_sig",   Signature, FF);
    chk("rst_rdv",   32'(Rd_Valid), 32'd0);
    Reset = 1'b1;

    // First event held for 3 cycles: one record.
    repeat (3) cyc(1, 32'd1, 32'd0, 32'd0, 0, 0);
    chk("first_count", 32'(Count), 32'd1);
    chk("first_sig",   Signature, 32'hFB3EE248);
    chk("first_ovf",   32'(Overflow), 32'd0);
    cyc(0, 32'd1, 32'd0, 32'd0, 1, 0);
    chk("first_rdv",   32'(Rd_Valid), 32'd1);
    chk("first_ralu",  Rd_ALU, 32'd1);
    chk("first_empty", 32'(Empty), 32'd1);

    // Change detection table (MEM=3, RF=9 fixed).
    tv[0]  = mk(0, 32'd0, 0, 1, 0, 0, 32'd0, 1);
    tv[1]  = mk(0, 32'd1, 0, 0, 0, 0, 32'd0, 1);
    tv[2]  = mk(0, 32'd2, 0, 0, 0, 0, 32'd0, 1);
    tv[3]  = mk(0, 32'd3, 0, 0, 0, 0, 32'd0, 1);
    tv[4]  = mk(1, 32'd5, 0, 0, 1, 0, 32'd0, 0);
    tv[5]  = mk(1, 32'd5, 0, 0, 1, 0, 32'd0, 0);
    tv[6]  = mk(1, 32'd7, 0, 0, 2, 0, 32'd0, 0);
    tv[7]  = mk(1, 32'd7, 0, 0, 2, 0, 32'd0, 0);
    tv[8]  = mk(1, 32'd5, 0, 0, 3, 0, 32'd0, 0);
    tv[9]  = mk(0, 32'd5, 1, 0, 2, 1, 32'd5, 0);
    tv[10] = mk(0, 32'd5, 1, 0, 1, 1, 32'd7, 0);
    tv[11] = mk(0, 32'd5, 1, 0, 0, 1, 32'd5, 0);
    tv[12] = mk(0, 32'd5, 1, 0, 0, 0, 32'd0, 0);
    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].cap, tv[i].alu, 32'd3, 32'd9, tv[i].rd, tv[i].clr);
      chk($sformatf("tv%0d_count", i), 32'(Count), 32'(tv[i].cnt));
      chk($sformatf("tv%0d_rdv", i), 32'(Rd_Valid), 32'(tv[i].rdv));
      if (tv[i].rdv)   chk($sformatf("tv%0d_ralu", i), Rd_ALU, tv[i].ralu);
      if (tv[i].sigff) chk($sformatf("tv%0d_sig", i), Signature, FF);
    end

    // Fill to full, simultaneous capture+pop at full, then overflow.
    cyc(0, 32'd0, 32'd0, 32'd0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h100 + 32'(i), 32'(i * 3), 32'(~i), 0, 0);
    chk("fill_full",  32'(Full), 32'd1);
    chk("fill_count", 32'(Count), 32'd16);
    chk("fill_ovf",   32'(Overflow), 32'd0);
    cyc(1, 32'h200, 32'd7, 32'd7, 1, 0);
    chk("simfull_count", 32'(Count), 32'd16);
    chk("simfull_ovf",   32'(Overflow), 32'd0);
    chk("simfull_ralu",  Rd_ALU, 32'h100);
    for (int i = 0; i < 2; i++) cyc(1, 32'h300 + 32'(i), 32'd1, 32'd2, 0, 0);
    chk("ovf_full",  32'(Full), 32'd1);
    chk("ovf_count", 32'(Count), 32'd16);
    chk("ovf_flag",  32'(Overflow), 32'd1);
    repeat (DEPTH + 1) cyc(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("drain_empty", 32'(Empty), 32'd1);
    chk("drain_ovf_sticky", 32'(Overflow), 32'd1);

    // Empty with simultaneous capture and pop.
    cyc(1, 32'h400, 32'd1, 32'd2, 1, 0);
    chk("simempty_count", 32'(Count), 32'd1);
    chk("simempty_rdv",   32'(Rd_Valid), 32'd0);

    // Wrap-around: 40 captures with pops, pointers pass the end twice.
    for (int i = 0; i < 40; i++) cyc(1, 32'h1000 + 32'(i), 32'(i), 32'(i * 5), 1, 0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("wrap_last", Rd_ALU, 32'h1027);
    chk("wrap_empty", 32'(Empty), 32'd1);

    // Clear together with capture and pop; unchanged triple recaptured after.
    cyc(1, 32'd55, 32'd1, 32'd1, 0, 0);
    cyc(1, 32'd66, 32'd1, 32'd1, 0, 0);
    cyc(1, 32'd66, 32'd1, 32'd1, 1, 1);
    chk("clr_count", 32'(Count), 32'd0);
    chk("clr_sig",   Signature, FF);
    chk("clr_rdv",   32'(Rd_Valid), 32'd0);
    chk("clr_ovf",   32'(Overflow), 32'd0);
    cyc(1, 32'd66, 32'd1, 32'd1, 0, 0);
    chk("clr_recap", 32'(Count), 32'd1);

    // Reset asserted mid-burst, between edges.
    cyc(1, 32'd77, 32'd2, 32'd3, 0, 0);
    cyc(1, 32'd78, 32'd2, 32'd3, 1, 0);
    #2 Reset = 1'b0;
    #1;
    chk("mrst_rdv",   32'(Rd_Valid), 32'd0);
    chk("mrst_ralu",  Rd_ALU, 32'd0);
    chk("mrst_count", 32'(Count), 32'd0);
    chk("mrst_empty", 32'(Empty), 32'd1);
    chk("mrst_full",  32'(Full), 32'd0);
    chk("mrst_ovf",   32'(Overflow), 32'd0);
    chk("mrst_sig",   Signature, FF);
    model_reset();
    #2 Reset = 1'b1;
    cyc(1, 32'd78, 32'd2, 32'd3, 0, 0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("post_rst_ralu", Rd_ALU, 32'd78);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
